// File: rtl/clk_en_gen_pkg.sv
// ============================================================================
// Package : clk_en_gen_pkg
// Brief   : Shared state encoding, mode constants and default widths.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package clk_en_gen_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/clk_en_gen_if.sv
// ============================================================================
// Interface : clk_en_gen_if
// Brief     : Control strobes, configuration and status of the generator.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic             stop;
  logic             mode;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] burst_len;
  logic             clk_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output start, stop, mode, div, burst_len,
    input  clk_en, busy, done, pulse_cnt
  );

  modport slave (
    input  start, stop, mode, div, burst_len,
    output clk_en, busy, done, pulse_cnt
  );

endinterface

`default_nettype wire

// File: rtl/clk_en_gen_en_prescaler.sv
// ============================================================================
// Module : en_prescaler
// Brief  : Divide counter; tick_o marks the cycle the count equals div_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module en_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/clk_en_gen.sv
// ============================================================================
// Module : clk_en_gen
// Brief  : Programmable clock-enable generator, continuous or burst mode.
//          Define CLK_EN_GEN_SYNC_IN_EN to synchronise asynchronous start/stop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  clk_en_gen_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic start_s;
  logic stop_s;

`ifdef CLK_EN_GEN_SYNC_IN_EN
  logic [2:0] start_sync_q;
  logic [2:0] stop_sync_q;

  // Two synchroniser stages, the third holds the previous level for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], bus.start};
      stop_sync_q  <= {stop_sync_q[1:0], bus.stop};
    end
  end

  assign start_s = start_sync_q[1] & ~start_sync_q[2];
  assign stop_s  = stop_sync_q[1] & ~stop_sync_q[2];
`else
  assign start_s = bus.start;
  assign stop_s  = bus.stop;
`endif

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;

  logic run;
  logic burst_reached;
  logic accept_start;
  logic tick;

  assign run           = (state_q == ST_RUN);
  assign burst_reached = (mode_q == MODE_BURST) && (cnt_q == len_q);
  assign accept_start  = start_s && !stop_s && !run;

  en_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept_start),
    .en_i   (run && !burst_reached),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    div_d    = div_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    clk_en_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept_start) begin
          mode_d = bus.mode;
          div_d  = bus.div;
          len_d  = bus.burst_len;
          cnt_d  = '0;
          // An empty burst completes without ever entering RUN.
          if ((bus.mode == MODE_BURST) && (bus.burst_len == '0)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_d = ST_IDLE;
        end else if (burst_reached) begin
          state_d = ST_DONE;
        end else if (tick) begin
          clk_en_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_CONT;
      div_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
    end
  end

  assign bus.clk_en    = clk_en_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pulse_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/clk_en_gen.md
Name: clk_en_gen

Overview:
- Programmable clock-enable generator that drives the clk_en input of the 3-bit register counter stage directly downstream.
- Produces single-cycle clk_en pulses at a divided rate, in either continuous or burst (N pulses then stop) mode.
- Start/stop is by control strobes, with busy/done status for the sequencing logic.

Parameters:
- DIV_W, 8, width of the divide-ratio input; pulse period = div+1 clocks.
- CNT_W, 8, width of the burst length and delivered-pulse counters.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset; all outputs and state go to 0 immediately.
- start  in  1  one-cycle strobe; begins generation from IDLE or DONE.
- stop  in  1  one-cycle strobe; aborts generation.
- mode  in  1  0 = continuous, 1 = burst; sampled with start.
- div  in  DIV_W  divide ratio; sampled with start.
- burst_len  in  CNT_W  pulse count for burst mode; sampled with start.
- clk_en  out  1  registered one-cycle enable pulse to the downstream counter.
- busy  out  1  high in RUN state.
- done  out  1  one-cycle pulse when a burst completes naturally (not on stop).
- pulse_cnt  out  CNT_W  number of clk_en pulses since the last start; saturates at all-ones.

Behaviour:
- Reset values: clk_en=0, busy=0, done=0, pulse_cnt=0, prescaler=0, state=IDLE.
- States: IDLE, RUN, DONE.
- IDLE/DONE -> RUN on start (stop=0):
  - latch mode, div and burst_len;
  - clear prescaler and pulse_cnt;
  - busy=1 from the next cycle.
- DONE -> IDLE after one cycle if no start; done=1 only during that DONE cycle.
- RUN, prescaler counting:
  - prescaler increments each cycle; at prescaler==div_latched it wraps to 0 and clk_en=1 for the next cycle.
  - First clk_en is high exactly div+1 cycles after the start-sampling edge.
  - Period is div+1; div=0 gives clk_en high every cycle while RUN.
- RUN, burst mode:
  - when the pulse that makes pulse_cnt==burst_len is issued, go to DONE;
  - busy drops the cycle after that last clk_en.
- Burst with burst_len=0: start goes straight to DONE; no clk_en, done pulses, pulse_cnt stays 0.
- Continuous mode: RUN until stop; pulse_cnt saturates and does not wrap.
- stop in RUN:
  - go to IDLE next cycle; clk_en forced 0 that cycle; no done pulse;
  - pulse_cnt holds its value until the next start.
- Simultaneous start and stop: stop wins; the block stays in or goes to IDLE.
- start while RUN: ignored; latched parameters do not change mid-run.
- Changes on div, mode or burst_len while RUN: no effect.
- rst asserted mid-run: immediate return to reset values. No pulse or partial pulse on clk_en after rst rises; clk_en is registered and cleared asynchronously.

Optional Feature:
- Macro CLK_EN_GEN_SYNC_IN_EN.
- Defined:
  - start and stop pass through a 2-flop synchronizer plus rising-edge detect before the FSM, for use from an asynchronous control source;
  - all start/stop-relative latencies grow by 2 cycles;
  - a level held high counts as one strobe.
- Undefined: start and stop feed the FSM directly as synchronous one-cycle strobes; latencies as above.

Decomposition:
- Package clk_en_gen_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - mode constants MODE_CONT=1'b0, MODE_BURST=1'b1;
  - default widths.
- Sub-module en_prescaler:
  - DIV_W-bit counter with clear, enable and terminal-count compare against the latched div;
  - outputs a tick that the FSM registers into clk_en.
- The FSM, latches and pulse counter stay in clk_en_gen.

Test Plan:
- Reset: rst high mid-RUN with div=3 -> clk_en, busy, done and pulse_cnt read 0 within the same cycle; no clk_en after release until a new start.
- Continuous div=2: start at cycle 0 -> clk_en high in cycles 3, 6, 9…; stop at cycle 10 -> busy=0 from cycle 11, pulse_cnt=3, done never asserted.
- Burst div=0, burst_len=5: clk_en high cycles 1–5; done high at cycle 6; busy low at cycle 6; pulse_cnt=5.
- Boundaries:
  - burst_len=0 -> no clk_en, done pulses 1 cycle after start;
  - start with stop in the same cycle -> remains IDLE;
  - start during RUN -> ignored, period unchanged.
- Saturation: continuous, div=0, CNT_W=4 -> pulse_cnt reaches 15 and holds; clk_en keeps pulsing.
- With CLK_EN_GEN_SYNC_IN_EN and a 4-cycle level on start, div=1 -> exactly one run starts; first clk_en 2 cycles later than without the macro.
- Downstream link: clk_en driving the register counter with div=1, burst_len=8 -> counter advances exactly 8 counts, wrapping 7 -> 0 once.
